// File: rtl/router_pkg.sv
// Shared router definitions: packet width, transmit-arbiter state encoding and
// the default TX_Ready fall timeout.
package router_pkg;

  localparam int PKT_W            = 55;
  localparam int DEF_BUSY_TIMEOUT = 8;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE      = 2'd0;
  localparam arb_state_t ST_ISSUE     = 2'd1;
  localparam arb_state_t ST_WAIT_BUSY = 2'd2;
  localparam arb_state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_REQ. Outputs a one-hot grant and its index.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] idx
);

  int               j;
  logic [PTR_W-1:0] cand;

  // Scan from the farthest offset down so the closest hit to ptr wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    j    = 0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      cand = PTR_W'(j);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one serial transmitter between N_REQ packet
// requesters; latches the winner, drives the TX handshake and watches TX_Ready.
module tx_arbiter
  import router_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = PKT_W,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                    Clk_S,
  input  logic                    Rst_n,
  input  logic [N_REQ*DATA_W-1:0] Req_Data,
  input  logic [N_REQ-1:0]        Req_Valid,
  output logic [N_REQ-1:0]        Req_Ack,
  output logic [N_REQ-1:0]        Grant,
  output logic [DATA_W-1:0]       TX_Data,
  output logic                    TX_Data_Valid,
  input  logic                    TX_Ready,
  output logic                    Busy,
  output logic                    Timeout_Err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;

  logic [N_REQ-1:0]  sel_gnt;
  logic [PTR_W-1:0]  sel_idx;

  rr_select #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_select (
    .req (Req_Valid),
    .ptr (rr_ptr_q),
    .gnt (sel_gnt),
    .idx (sel_idx)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    ack_d    = '0;
    cnt_d    = cnt_q;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A busy transmitter blocks arbitration entirely, so no ack is given early.
        if (TX_Ready && (|Req_Valid)) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (sel_gnt[i]) hold_d = Req_Data[i*DATA_W +: DATA_W];
          end
          grant_d  = sel_gnt;
          ack_d    = sel_gnt;
          rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + PTR_W'(1);
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (TX_Ready) begin
          cnt_d   = '0;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // The packet was already acked, so a timeout simply drops it.
        if (!TX_Ready) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (TX_Ready) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_S or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      hold_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign Req_Ack       = ack_q;
  assign Grant         = grant_q;
  assign TX_Data       = hold_q;
  assign TX_Data_Valid = (state_q == ST_ISSUE);
  assign Busy          = (state_q != ST_IDLE);
  assign Timeout_Err   = tmo_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: transaction-level arbiter model compared every
// cycle, a behavioural transmitter, and literal expectations per scenario.
module tb_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 55;
  localparam int TMO = 8;

  logic             clk = 1'b0;
  logic             Rst_n = 1'b1;
  logic [NR*DW-1:0] Req_Data;
  logic [NR-1:0]    rv = '0;
  logic [NR-1:0]    Req_Ack;
  logic [NR-1:0]    Grant;
  logic [DW-1:0]    TX_Data;
  logic             TX_Data_Valid;
  logic             TX_Ready = 1'b1;
  logic             Busy;
  logic             Timeout_Err;

  logic [DW-1:0]    rd [NR];

  tx_arbiter #(.N_REQ(NR), .DATA_W(DW), .BUSY_TIMEOUT(TMO)) dut (
    .Clk_S         (clk),
    .Rst_n         (Rst_n),
    .Req_Data      (Req_Data),
    .Req_Valid     (rv),
    .Req_Ack       (Req_Ack),
    .Grant         (Grant),
    .TX_Data       (TX_Data),
    .TX_Data_Valid (TX_Data_Valid),
    .TX_Ready      (TX_Ready),
    .Busy          (Busy),
    .Timeout_Err   (Timeout_Err)
  );

  always #5 clk = ~clk;

  always_comb begin
    Req_Data = '0;
    for (int i = 0; i < NR; i++) Req_Data[i*DW +: DW] = rd[i];
  end

  // Arbiter model: one owner at a time, one issue strobe, then either the
  // transmitter goes busy or TMO ready cycles expire.
  int            m_owner   = -1;
  int            m_ptr     = 0;
  int            m_since   = 0;
  bit            m_issue   = 1'b0;
  bit            m_dropped = 1'b0;
  bit            m_tmo     = 1'b0;
  logic [NR-1:0] m_ack     = '0;
  logic [DW-1:0] m_hold    = '0;

  function automatic int pick(input logic [NR-1:0] v, input int p);
    logic [NR-1:0] s;
    for (int k = 0; k < NR; k++) begin
      s = v >> ((p + k) % NR);
      if (s[0]) return (p + k) % NR;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_owner <= -1; m_ptr <= 0; m_since <= 0; m_issue <= 1'b0;
      m_dropped <= 1'b0; m_tmo <= 1'b0; m_ack <= '0; m_hold <= '0;
    end else begin
      m_ack <= '0;
      m_tmo <= 1'b0;
      if (m_owner < 0) begin
        if (TX_Ready && rv != '0) begin
          m_owner <= pick(rv, m_ptr);
          m_hold  <= rd[pick(rv, m_ptr)];
          m_ack   <= NR'(1) << pick(rv, m_ptr);
          m_ptr   <= (pick(rv, m_ptr) + 1) % NR;
          m_issue <= 1'b1;
        end
      end else if (m_issue) begin
        if (TX_Ready) begin
          m_issue <= 1'b0; m_since <= 0; m_dropped <= 1'b0;
        end
      end else if (!m_dropped) begin
        if (!TX_Ready) m_dropped <= 1'b1;
        else if (m_since + 1 == TMO) begin
          m_tmo <= 1'b1; m_owner <= -1;
        end else m_since <= m_since + 1;
      end else if (TX_Ready) begin
        m_owner <= -1;
      end
    end
  end

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            tx_mode = 0;   // 0 normal, 1 never busy, 2 TX_Ready driven by stimulus
  int            tx_cnt = 0;
  bit            dv_n, rdy_n;
  int            dv_hi = 0;
  int            ack_cnt [NR];
  bit            auto_drop [NR];
  int            glog [$];
  logic [DW-1:0] dlog [$];
  int            ack_cyc = 0;
  int            tmo_cnt = 0;
  int            tmo_cyc [$];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s at cycle %0d: actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic tick();
    logic [63:0] eg;
    @(negedge clk);
    dv_n  = TX_Data_Valid;
    rdy_n = TX_Ready;
    eg = (m_owner < 0) ? 64'd0 : (64'd1 << m_owner);
    chk("grant",   64'(Grant), eg);
    chk("req_ack", 64'(Req_Ack), 64'(m_ack));
    chk("tx_valid", 64'(TX_Data_Valid), 64'(m_issue));
    chk("tx_data", 64'(TX_Data), 64'(m_hold));
    chk("busy",    64'(Busy), 64'(m_owner >= 0));
    chk("timeout", 64'(Timeout_Err), 64'(m_tmo));
    @(posedge clk);
    #1;
    cyc++;
    if (dv_n) dv_hi++;
    if (tx_mode != 2) begin
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) TX_Ready = 1'b1;
      end else if (dv_n && rdy_n && tx_mode == 0) begin
        TX_Ready = 1'b0;
        tx_cnt   = 57;
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (Req_Ack[i]) begin
        glog.push_back(i);
        dlog.push_back(TX_Data);
        ack_cnt[i]++;
        ack_cyc = cyc;
        if (auto_drop[i]) rv[i] = 1'b0;
      end
    end
    if (Timeout_Err) begin
      tmo_cnt++;
      tmo_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset(input logic rdy);
    Rst_n    = 1'b0;
    rv       = '0;
    TX_Ready = rdy;
    tx_cnt   = 0;
    for (int i = 0; i < NR; i++) auto_drop[i] = 1'b1;
    tick();
    tick();
    glog.delete();
    dlog.delete();
    tmo_cyc.delete();
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    tmo_cnt = 0;
    dv_hi   = 0;
    Rst_n   = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget, input string nm);
    int c = 0;
    while (glog.size() < n && c < budget) begin tick(); c++; end
    chk(nm, 64'(glog.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int c = 0;
    while (!(Busy == 1'b0 && TX_Ready == 1'b1) && c < budget) begin tick(); c++; end
    chk(nm, {62'd0, Busy, TX_Ready}, 64'd1);
  endtask

  task automatic wait_tmo(input int n, input int budget, input string nm);
    int c = 0;
    while (tmo_cnt < n && c < budget) begin tick(); c++; end
    chk(nm, 64'(tmo_cnt), 64'(n));
  endtask

  initial begin
    int t;
    for (int i = 0; i < NR; i++) begin rd[i] = '0; ack_cnt[i] = 0; auto_drop[i] = 1'b1; end
    #1 Rst_n = 1'b0;
    #1;
    chk("rst_outputs", {Req_Ack, Grant, TX_Data_Valid, Busy, Timeout_Err}, 64'd0);
    chk("rst_txdata", 64'(TX_Data), 64'd0);

    // Scenario 1: single requester 2
    do_reset(1'b1);
    rd[2] = 55'd3;
    rv    = 4'b0100;
    wait_log(1, 20, "s1_ack");
    chk("s1_winner", 64'(glog[0]), 64'd2);
    chk("s1_grant", 64'(Grant), 64'b0100);
    chk("s1_valid_latency", 64'(TX_Data_Valid), 64'd1);
    chk("s1_data", 64'(dlog[0]), 64'd3);
    wait_idle(120, "s1_idle");
    chk("s1_ack_count", 64'(ack_cnt[2]), 64'd1);
    chk("s1_valid_cycles", 64'(dv_hi), 64'd1);
    chk("s1_grant_idle", 64'(Grant), 64'd0);

    // Scenario 2: all four at once
    do_reset(1'b1);
    for (int i = 0; i < NR; i++) rd[i] = DW'(i + 1);
    rv = 4'b1111;
    wait_log(4, 400, "s2_four_acks");
    wait_idle(120, "s2_idle");
    for (int i = 0; i < NR; i++) begin
      chk("s2_order", 64'(glog[i]), 64'(i));
      chk("s2_data", 64'(dlog[i]), 64'(i + 1));
      chk("s2_ack_once", 64'(ack_cnt[i]), 64'd1);
    end

    // Scenario 3: fairness with requester 0 held valid
    do_reset(1'b1);
    auto_drop[0] = 1'b0;
    rd[0] = 55'd10;
    rd[2] = 55'd20;
    rv    = 4'b0001;
    wait_log(1, 20, "s3_first");
    repeat (5) tick();
    rv[2] = 1'b1;
    wait_log(3, 300, "s3_three");
    rv[0] = 1'b0;
    wait_idle(120, "s3_idle");
    chk("s3_g0", 64'(glog[0]), 64'd0);
    chk("s3_g1", 64'(glog[1]), 64'd2);
    chk("s3_g2", 64'(glog[2]), 64'd0);
    chk("s3_ack2_once", 64'(ack_cnt[2]), 64'd1);

    // Scenario 4: transmitter not ready after reset
    tx_mode = 2;
    do_reset(1'b0);
    rd[0] = 55'h5A;
    rv    = 4'b0001;
    repeat (5) tick();
    chk("s4_no_ack", 64'(ack_cnt[0]), 64'd0);
    chk("s4_no_grant", 64'(Grant), 64'd0);
    chk("s4_not_busy", 64'(Busy), 64'd0);
    TX_Ready = 1'b1;
    tx_mode  = 0;
    t = cyc;
    wait_log(1, 5, "s4_ack");
    chk("s4_grant_delay", 64'(ack_cyc - t), 64'd1);
    chk("s4_grant", 64'(Grant), 64'b0001);
    wait_idle(120, "s4_idle");

    // Scenario 5: transmitter never goes busy
    tx_mode = 1;
    do_reset(1'b1);
    rd[1] = 55'h11;
    rd[3] = 55'h33;
    rv    = 4'b1010;
    wait_log(1, 10, "s5_first");
    t = ack_cyc;
    wait_tmo(1, 30, "s5_tmo1");
    chk("s5_tmo_delay", 64'(tmo_cyc[0] - t), 64'd9);
    chk("s5_idle_after_tmo", {62'd0, Busy, Grant != '0}, 64'd0);
    wait_log(2, 20, "s5_second");
    chk("s5_next_winner", 64'(glog[1]), 64'd3);
    wait_tmo(2, 30, "s5_tmo2");
    tx_mode = 0;
    wait_idle(30, "s5_idle");
    repeat (3) tick();
    chk("s5_tmo_pulses", 64'(tmo_cnt), 64'd2);

    // Scenario 6: asynchronous reset mid-transfer
    tx_mode = 0;
    do_reset(1'b1);
    rd[2] = 55'b101101110_1110001110_101101110_1110001110_101101110_11101;
    rv    = 4'b0100;
    wait_log(1, 10, "s6_first");
    chk("s6_data", 64'(dlog[0]), 64'(55'b101101110_1110001110_101101110_1110001110_101101110_11101));
    repeat (30) tick();
    #2 Rst_n = 1'b0;
    #1;
    chk("s6_async_ctl", {Req_Ack, Grant, TX_Data_Valid, Busy, Timeout_Err}, 64'd0);
    chk("s6_async_data", 64'(TX_Data), 64'd0);
    rd[0] = 55'h100;
    rd[3] = 55'h300;
    rv    = 4'b1001;
    tick();
    tick();
    Rst_n = 1'b1;
    wait_log(2, 100, "s6_after_rst");
    chk("s6_ptr_reset", 64'(glog[1]), 64'd0);
    wait_log(3, 120, "s6_third");
    chk("s6_third_winner", 64'(glog[2]), 64'd3);
    wait_idle(120, "s6_idle");
    chk("s6_no_reack", 64'(ack_cnt[2]), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
